// File: rtl/pcs_fifo_pkg.sv
// pcs_fifo_pkg
//   Helpers and limits shared by the PCS TX async FIFO pointer synchronisers
//   (w2r and r2w directions).
//   - SYNC_STAGES_MIN/MAX : legal synchroniser chain depths.
//   - PTR_W_MAX           : widest pointer the helper functions handle.
//   - gray2bin()          : Gray -> binary for any width up to PTR_W_MAX.
//                           Narrower pointers are zero-extended by the caller
//                           and the result is truncated back.
//   - popcount()          : number of set bits.
package pcs_fifo_pkg;

  localparam int unsigned SYNC_STAGES_MIN = 2;
  localparam int unsigned SYNC_STAGES_MAX = 4;
  localparam int unsigned PTR_W_MAX       = 32;

  typedef logic [PTR_W_MAX-1:0] ptr_max_t;

  // Binary bit i is the XOR of all Gray bits at or above i. XOR-ing every
  // right shift of the word builds that prefix parity for all bits at once.
  // Zero-extension leaves the result unchanged, so the function works for
  // any pointer width up to PTR_W_MAX.
  function automatic ptr_max_t gray2bin(input ptr_max_t gray);
    ptr_max_t bin;
    bin = gray;
    for (int i = 1; i < PTR_W_MAX; i++) begin
      bin ^= (gray >> i);
    end
    return bin;
  endfunction

  function automatic int unsigned popcount(input ptr_max_t v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < PTR_W_MAX; i++) begin
      if (v[i]) n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/sync_ff_chain.sv
// sync_ff_chain
//   Generic multi-flop synchroniser: STAGES flops in series, every flop
//   clears to 0 on an asynchronous active-low reset. All stages carry
//   ASYNC_REG so that placement keeps them together and timing treats the
//   first stage as a metastability capture flop.
//   Ports:
//     clk    in   1      destination-domain clock
//     rst_n  in   1      asynchronous, active-low reset
//     d      in   WIDTH  asynchronous input
//     q      out  WIDTH  synchronised output (last stage)
module sync_ff_chain #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] stage_q [STAGES];
  logic [WIDTH-1:0] stage_d [STAGES];

  always_comb begin
    stage_d[0] = d;
    for (int k = 1; k < STAGES; k++) begin
      stage_d[k] = stage_q[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        stage_q[k] <= '0;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: rtl/sync_w2r_gray_mon.sv
// sync_w2r_gray_mon
//   Brings the Gray-coded write pointer of the PCS TX async FIFO into the
//   read clock domain and derives, in rclk:
//     - the binary pointer,
//     - the pointer advance since the previous cycle (modular delta),
//     - a Gray-integrity monitor that flags samples differing in more than
//       one bit, with a saturating error counter.
//   After reset a warm-up counter waits for the chain and decode stage to be
//   filled with real samples before delta and the error outputs are trusted.
//   Ports:
//     rclk           in   1           read-domain clock
//     rrst_n         in   1           asynchronous, active-low reset
//     wptr           in   ADDRSIZE+1  Gray write pointer (asynchronous)
//     err_clr        in   1           synchronous clear of err_cnt
//     rq_wptr_gray   out  ADDRSIZE+1  synchronised Gray pointer
//     rq_wptr_bin    out  ADDRSIZE+1  registered binary pointer
//     rq_wptr_delta  out  ADDRSIZE+1  registered pointer advance (mod 2^W)
//     sync_valid     out  1           pipeline flushed since reset
//     gray_err       out  1           one-cycle pulse on a multi-bit change
//     err_cnt        out  CNTW        saturating count of gray_err pulses
module sync_w2r_gray_mon
  import pcs_fifo_pkg::*;
#(
  parameter int unsigned ADDRSIZE = 7,
  parameter int unsigned STAGES   = 2,
  parameter int unsigned CNTW     = 8
) (
  input  logic              rclk,
  input  logic              rrst_n,
  input  logic [ADDRSIZE:0] wptr,
  input  logic              err_clr,
  output logic [ADDRSIZE:0] rq_wptr_gray,
  output logic [ADDRSIZE:0] rq_wptr_bin,
  output logic [ADDRSIZE:0] rq_wptr_delta,
  output logic              sync_valid,
  output logic              gray_err,
  output logic [CNTW-1:0]   err_cnt
);

  localparam int unsigned PW  = ADDRSIZE + 1;
  // Warm-up count runs 0..STAGES+1, so it needs room for STAGES+2 values.
  localparam int unsigned WUW = $clog2(STAGES + 2);

  typedef logic [PW-1:0]   ptr_t;
  typedef logic [WUW-1:0]  wu_t;
  typedef logic [CNTW-1:0] cnt_t;

  localparam wu_t  WU_DONE = wu_t'(STAGES + 1);
  localparam cnt_t CNT_MAX = '1;

  generate
    if (STAGES < SYNC_STAGES_MIN || STAGES > SYNC_STAGES_MAX) begin : g_bad_stages
      $error("sync_w2r_gray_mon: STAGES must be in 2..4");
    end
    if (PW > PTR_W_MAX) begin : g_bad_width
      $error("sync_w2r_gray_mon: pointer wider than pcs_fifo_pkg supports");
    end
  endgenerate

  ptr_t rq_gray;

  wu_t  wu_cnt_q,    wu_cnt_d;
  ptr_t bin_q,       bin_d;
  ptr_t delta_q,     delta_d;
  ptr_t gray_prev_q, gray_prev_d;
  logic gray_err_q,  gray_err_d;
  cnt_t err_cnt_q,   err_cnt_d;

  ptr_t bin_dec;
  logic multi_bit;
  logic valid;

  sync_ff_chain #(
    .WIDTH  (PW),
    .STAGES (STAGES)
  ) u_chain (
    .clk   (rclk),
    .rst_n (rrst_n),
    .d     (wptr),
    .q     (rq_gray)
  );

  assign valid     = (wu_cnt_q == WU_DONE);
  assign bin_dec   = ptr_t'(gray2bin(ptr_max_t'(rq_gray)));
  assign multi_bit = (popcount(ptr_max_t'(rq_gray ^ gray_prev_q)) > 32'd1);

  always_comb begin
    wu_cnt_d    = valid ? wu_cnt_q : wu_cnt_q + wu_t'(1);
    bin_d       = bin_dec;
    gray_prev_d = rq_gray;
    // Unsigned wrap of the subtraction turns an all-ones -> 0 step into +1.
    delta_d     = valid ? (bin_dec - bin_q) : '0;
    gray_err_d  = valid & multi_bit;

    err_cnt_d = err_cnt_q;
    if (err_clr) begin
      // A clear that lands on an error keeps that error counted.
      err_cnt_d = gray_err_q ? cnt_t'(1) : '0;
    end else if (valid && gray_err_q && (err_cnt_q != CNT_MAX)) begin
      err_cnt_d = err_cnt_q + cnt_t'(1);
    end
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      wu_cnt_q    <= '0;
      bin_q       <= '0;
      delta_q     <= '0;
      gray_prev_q <= '0;
      gray_err_q  <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      wu_cnt_q    <= wu_cnt_d;
      bin_q       <= bin_d;
      delta_q     <= delta_d;
      gray_prev_q <= gray_prev_d;
      gray_err_q  <= gray_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign rq_wptr_gray  = rq_gray;
  assign rq_wptr_bin   = bin_q;
  assign rq_wptr_delta = delta_q;
  assign sync_valid    = valid;
  assign gray_err      = gray_err_q;
  assign err_cnt       = err_cnt_q;

endmodule

// File: tb/tb_sync_w2r_gray_mon.sv
// Two instances share clock, reset and stimulus:
//   dut_a : ADDRSIZE=7, STAGES=2, CNTW=4
//   dut_b : ADDRSIZE=7, STAGES=3, CNTW=8
// The reference model keeps the history of wptr values sampled at each rclk
// edge since reset and computes every output from that history.
module tb_sync_w2r_gray_mon;

  logic       rclk = 1'b0;
  logic       rrst_n;
  logic [7:0] wptr;
  logic       err_clr;

  logic [7:0] gray_a, bin_a, delta_a;
  logic       valid_a, err_a;
  logic [3:0] cnt_a;
  logic [7:0] gray_b, bin_b, delta_b;
  logic       valid_b, err_b;
  logic [7:0] cnt_b;

  always #5 rclk = ~rclk;

  sync_w2r_gray_mon #(.ADDRSIZE(7), .STAGES(2), .CNTW(4)) dut_a (
    .rclk(rclk), .rrst_n(rrst_n), .wptr(wptr), .err_clr(err_clr),
    .rq_wptr_gray(gray_a), .rq_wptr_bin(bin_a), .rq_wptr_delta(delta_a),
    .sync_valid(valid_a), .gray_err(err_a), .err_cnt(cnt_a)
  );

  sync_w2r_gray_mon #(.ADDRSIZE(7), .STAGES(3), .CNTW(8)) dut_b (
    .rclk(rclk), .rrst_n(rrst_n), .wptr(wptr), .err_clr(err_clr),
    .rq_wptr_gray(gray_b), .rq_wptr_bin(bin_b), .rq_wptr_delta(delta_b),
    .sync_valid(valid_b), .gray_err(err_b), .err_cnt(cnt_b)
  );

  int         checks = 0;
  int         errors = 0;
  logic [7:0] hist[$];
  int         m_cnt [2];
  int         m_max [2] = '{15, 255};
  logic [7:0] bcnt;

  // ---------------- reference model ----------------
  function automatic logic [7:0] m_g2b(input logic [7:0] g);
    logic [7:0] b;
    b[7] = g[7];
    for (int i = 6; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // wptr sampled at edge k (k = 1 is the first edge after reset release).
  function automatic logic [7:0] H(input int k);
    if (k >= 1 && k <= hist.size()) return hist[k-1];
    return 8'h00;
  endfunction

  function automatic logic [7:0] fg(input int s, input int m);
    return H(m - s + 1);
  endfunction

  function automatic logic [7:0] fb(input int s, input int m);
    return m_g2b(H(m - s));
  endfunction

  function automatic logic fv(input int s, input int m);
    return (m >= s + 1);
  endfunction

  function automatic logic [7:0] fdelta(input int s, input int m);
    logic [7:0] d;
    d = 8'h00;
    if (m >= 1 && fv(s, m - 1)) d = fb(s, m) - fb(s, m - 1);
    return d;
  endfunction

  function automatic logic ferr(input int s, input int m);
    if (m < 1 || !fv(s, m - 1)) return 1'b0;
    return ($countones(fg(s, m - 1) ^ fg(s, m - 2)) > 1);
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_dut(input string p, input int s, input int d,
                         input logic [7:0] og, input logic [7:0] ob,
                         input logic [7:0] od, input logic ov,
                         input logic oe, input logic [7:0] oc);
    int n;
    n = hist.size();
    chk({p, "_gray"},  32'(og), 32'(fg(s, n)));
    chk({p, "_bin"},   32'(ob), 32'(fb(s, n)));
    chk({p, "_delta"}, 32'(od), 32'(fdelta(s, n)));
    chk({p, "_valid"}, 32'(ov), 32'(fv(s, n)));
    chk({p, "_err"},   32'(oe), 32'(ferr(s, n)));
    chk({p, "_cnt"},   32'(oc), 32'(m_cnt[d]));
  endtask

  task automatic step();
    logic [7:0] w;
    logic       c;
    int         n;
    int         s;
    w = wptr;
    c = err_clr;
    @(posedge rclk);
    hist.push_back(w);
    n = hist.size();
    for (int d = 0; d < 2; d++) begin
      s = (d == 0) ? 2 : 3;
      if (c) m_cnt[d] = ferr(s, n - 1) ? 1 : 0;
      else if (ferr(s, n - 1) && m_cnt[d] < m_max[d]) m_cnt[d]++;
    end
    #1;
    chk_dut("a", 2, 0, gray_a, bin_a, delta_a, valid_a, err_a, {4'b0, cnt_a});
    chk_dut("b", 3, 1, gray_b, bin_b, delta_b, valid_b, err_b, cnt_b);
  endtask

  // Short off-edge reset pulse; outputs must clear while rrst_n is low.
  task automatic do_reset();
    rrst_n = 1'b0;
    #1;
    chk("rst_a_gray", 32'(gray_a), 32'd0);
    chk("rst_a_bin", 32'(bin_a), 32'd0);
    chk("rst_a_delta", 32'(delta_a), 32'd0);
    chk("rst_a_valid", 32'(valid_a), 32'd0);
    chk("rst_a_err", 32'(err_a), 32'd0);
    chk("rst_a_cnt", 32'(cnt_a), 32'd0);
    chk("rst_b_gray", 32'(gray_b), 32'd0);
    chk("rst_b_bin", 32'(bin_b), 32'd0);
    chk("rst_b_delta", 32'(delta_b), 32'd0);
    chk("rst_b_valid", 32'(valid_b), 32'd0);
    chk("rst_b_err", 32'(err_b), 32'd0);
    chk("rst_b_cnt", 32'(cnt_b), 32'd0);
    rrst_n = 1'b1;
    hist.delete();
    m_cnt = '{0, 0};
  endtask

  task automatic count_step();
    if ($urandom_range(0, 1) == 1) bcnt = bcnt + 8'd1;
    wptr    = bcnt ^ (bcnt >> 1);
    err_clr = ($urandom_range(0, 15) == 0);
    step();
  endtask

  initial begin
    wptr    = 8'h00;
    err_clr = 1'b0;
    rrst_n  = 1'b0;
    bcnt    = 8'h00;
    m_cnt   = '{0, 0};
    #2;
    do_reset();

    // warm-up with wptr = 0
    step();
    step();
    chk("a_valid_edge2", 32'(valid_a), 32'd0);
    step();
    chk("a_valid_edge3", 32'(valid_a), 32'd1);
    step();
    step();
    step();

    // latency through the 3-stage chain
    wptr = 8'h01;
    step();
    step();
    step();
    chk("b_gray_lat3", 32'(gray_b), 32'h01);
    chk("b_bin_lat3", 32'(bin_b), 32'd0);
    step();
    chk("b_bin_lat4", 32'(bin_b), 32'd1);
    chk("b_delta_lat4", 32'(delta_b), 32'd1);
    bcnt = 8'h01;

    // random legal Gray counting with occasional clears
    repeat (200) count_step();
    err_clr = 1'b0;

    // wrap 255 -> 0
    wptr = 8'h80;
    repeat (6) step();
    wptr = 8'h00;
    step();
    step();
    step();
    chk("a_bin_wrap", 32'(bin_a), 32'd0);
    chk("a_delta_wrap", 32'(delta_a), 32'd1);
    chk("a_err_wrap", 32'(err_a), 32'd0);
    step();
    chk("b_bin_wrap", 32'(bin_b), 32'd0);
    chk("b_delta_wrap", 32'(delta_b), 32'd1);
    step();
    step();

    // clear, then a two-bit corruption
    repeat (4) step();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    step();
    wptr = 8'h03;
    step();
    step();
    chk("a_err_pre", 32'(err_a), 32'd0);
    step();
    chk("a_err_pulse", 32'(err_a), 32'd1);
    step();
    chk("a_err_after", 32'(err_a), 32'd0);
    chk("a_cnt_one", 32'(cnt_a), 32'd1);
    repeat (3) step();

    // saturation and clear behaviour
    repeat (24) begin
      wptr = (wptr == 8'h03) ? 8'h00 : 8'h03;
      step();
    end
    chk("a_cnt_sat", 32'(cnt_a), 32'd15);
    wptr    = (wptr == 8'h03) ? 8'h00 : 8'h03;
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("a_cnt_clr_err", 32'(cnt_a), 32'd1);
    repeat (6) step();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("a_cnt_clr", 32'(cnt_a), 32'd0);
    chk("b_cnt_clr", 32'(cnt_b), 32'd0);

    // reset in the middle of counting
    wptr = bcnt ^ (bcnt >> 1);
    repeat (6) step();
    repeat (10) count_step();
    err_clr = 1'b0;
    #2;
    do_reset();
    repeat (30) count_step();
    err_clr = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
